// File: rtl/axi_rd_slave_responder_pkg.sv
// Shared AXI encodings and the responder FSM state type.
package axi_rd_slave_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {IDLE, LOAD, BEAT} rsp_state_t;

endpackage

// File: rtl/axi_rd_slave_responder_picker.sv
// Combinational pick of the oldest or newest eligible slot by wrap-aware sequence number.
module rsp_slot_picker #(
  parameter int unsigned SLOTS = 8
) (
  input  logic [SLOTS-1:0]                  eligible,
  input  logic [SLOTS-1:0][$clog2(SLOTS):0] seq,
  input  logic                              order_mode,
  output logic [$clog2(SLOTS)-1:0]          idx,
  output logic                              found
);

  localparam int unsigned IdxW = $clog2(SLOTS);
  localparam int unsigned SeqW = IdxW + 1;

  // a precedes b when (a - b) is negative modulo 2^SeqW
  function automatic logic seq_before(input logic [SeqW-1:0] a, input logic [SeqW-1:0] b);
    logic [SeqW-1:0] diff;
    diff = a - b;
    return diff[SeqW-1];
  endfunction

  logic [SeqW-1:0] best;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    best  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (eligible[i]) begin
        if (!found || (order_mode ? seq_before(best, seq[i]) : seq_before(seq[i], best))) begin
          found = 1'b1;
          idx   = IdxW'(i);
          best  = seq[i];
        end
      end
    end
  end

endmodule

// File: rtl/axi_rd_slave_responder.sv
// AXI read slave endpoint: buffers AR requests and returns address-derived R bursts in
// oldest-first or newest-first order.
module axi_rd_slave_responder
  import axi_rd_slave_responder_pkg::*;
#(
  parameter int unsigned     ID_WIDTH    = 4,
  parameter int unsigned     ADDR_WIDTH  = 32,
  parameter int unsigned     DATA_WIDTH  = 64,
  parameter int unsigned     RESP_WIDTH  = 2,
  parameter int unsigned     LEN_WIDTH   = 8,
  parameter int unsigned     SIZE_WIDTH  = 3,
  parameter int unsigned     BURST_WIDTH = 2,
  parameter int unsigned     SLOTS       = 8,
  parameter int unsigned     MAX_LEN     = 8,
  parameter int unsigned     RESP_DELAY  = 4,
  parameter logic [DATA_WIDTH-1:0] DATA_SEED = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   order_mode,
  input  logic                   ar_valid,
  output logic                   ar_ready,
  input  logic [ID_WIDTH-1:0]    ar_id,
  input  logic [ADDR_WIDTH-1:0]  ar_addr,
  input  logic [LEN_WIDTH-1:0]   ar_len,
  input  logic [SIZE_WIDTH-1:0]  ar_size,
  input  logic [BURST_WIDTH-1:0] ar_burst,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [ID_WIDTH-1:0]    r_id,
  output logic [DATA_WIDTH-1:0]  r_data,
  output logic [RESP_WIDTH-1:0]  r_resp,
  output logic                   r_last,
  output logic                   busy
);

  localparam int unsigned IdxW = $clog2(SLOTS);
  localparam int unsigned SeqW = IdxW + 1;
  localparam int unsigned AgeW = (RESP_DELAY > 0) ? $clog2(RESP_DELAY + 1) : 1;

  logic [SLOTS-1:0]            slot_valid_q;
  logic [ID_WIDTH-1:0]         slot_id_q    [SLOTS];
  logic [ADDR_WIDTH-1:0]       slot_addr_q  [SLOTS];
  logic [LEN_WIDTH-1:0]        slot_len_q   [SLOTS];
  logic [SIZE_WIDTH-1:0]       slot_size_q  [SLOTS];
  logic [BURST_WIDTH-1:0]      slot_burst_q [SLOTS];
  logic [AgeW-1:0]             slot_age_q   [SLOTS];
  logic [SLOTS-1:0][SeqW-1:0]  slot_seq_q;
  logic [SeqW-1:0]             seq_ctr_q;

  rsp_state_t                  state_q, state_d;
  logic [IdxW-1:0]             act_idx_q, act_idx_d, pick_idx, free_idx;
  logic                        pick_found, accept, release_slot;
  logic [SLOTS-1:0]            eligible;

  logic [ID_WIDTH-1:0]         cur_id_q, cur_id_d;
  logic [ADDR_WIDTH-1:0]       cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]        cur_len_q, cur_len_d, beat_q, beat_d;
  logic [SIZE_WIDTH-1:0]       cur_size_q, cur_size_d;
  logic [BURST_WIDTH-1:0]      cur_burst_q, cur_burst_d;
  logic [RESP_WIDTH-1:0]       cur_resp_q, cur_resp_d;

  assign ar_ready = ~&slot_valid_q;
  assign accept   = ar_valid & ar_ready;

  always_comb begin
    free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!slot_valid_q[i]) free_idx = IdxW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      eligible[i] = slot_valid_q[i] && (slot_age_q[i] == AgeW'(RESP_DELAY)) &&
                    !((state_q != IDLE) && (act_idx_q == IdxW'(i)));
    end
  end

  rsp_slot_picker #(
    .SLOTS (SLOTS)
  ) u_picker (
    .eligible   (eligible),
    .seq        (slot_seq_q),
    .order_mode (order_mode),
    .idx        (pick_idx),
    .found      (pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= '0;
      slot_seq_q   <= '0;
      seq_ctr_q    <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_id_q[i]    <= '0;
        slot_addr_q[i]  <= '0;
        slot_len_q[i]   <= '0;
        slot_size_q[i]  <= '0;
        slot_burst_q[i] <= '0;
        slot_age_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (slot_valid_q[i] && (slot_age_q[i] != AgeW'(RESP_DELAY))) begin
          slot_age_q[i] <= slot_age_q[i] + AgeW'(1);
        end
      end
      if (release_slot) slot_valid_q[act_idx_q] <= 1'b0;
      // free_idx comes from registered state, so it never aliases the slot being released
      if (accept) begin
        slot_valid_q[free_idx] <= 1'b1;
        slot_id_q[free_idx]    <= ar_id;
        slot_addr_q[free_idx]  <= ar_addr;
        slot_len_q[free_idx]   <= ar_len;
        slot_size_q[free_idx]  <= ar_size;
        slot_burst_q[free_idx] <= ar_burst;
        slot_age_q[free_idx]   <= '0;
        slot_seq_q[free_idx]   <= seq_ctr_q;
        seq_ctr_q              <= seq_ctr_q + SeqW'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    act_idx_d    = act_idx_q;
    cur_id_d     = cur_id_q;
    cur_addr_d   = cur_addr_q;
    cur_len_d    = cur_len_q;
    cur_size_d   = cur_size_q;
    cur_burst_d  = cur_burst_q;
    cur_resp_d   = cur_resp_q;
    beat_d       = beat_q;
    release_slot = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          act_idx_d = pick_idx;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        cur_id_d    = slot_id_q[act_idx_q];
        cur_addr_d  = slot_addr_q[act_idx_q];
        cur_len_d   = slot_len_q[act_idx_q];
        cur_size_d  = slot_size_q[act_idx_q];
        cur_burst_d = slot_burst_q[act_idx_q];
        cur_resp_d  = (32'(slot_len_q[act_idx_q]) >= MAX_LEN) ? RESP_WIDTH'(RESP_SLVERR)
                                                              : RESP_WIDTH'(RESP_OKAY);
        beat_d      = '0;
        state_d     = BEAT;
      end
      BEAT: begin
        if (r_ready) begin
          if (beat_q == cur_len_q) begin
            release_slot = 1'b1;
            state_d      = IDLE;
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
            if (cur_burst_q != BURST_WIDTH'(BURST_FIXED)) begin
              cur_addr_d = cur_addr_q + (ADDR_WIDTH'(1) << cur_size_q);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      act_idx_q   <= '0;
      cur_id_q    <= '0;
      cur_addr_q  <= '0;
      cur_len_q   <= '0;
      cur_size_q  <= '0;
      cur_burst_q <= '0;
      cur_resp_q  <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      act_idx_q   <= act_idx_d;
      cur_id_q    <= cur_id_d;
      cur_addr_q  <= cur_addr_d;
      cur_len_q   <= cur_len_d;
      cur_size_q  <= cur_size_d;
      cur_burst_q <= cur_burst_d;
      cur_resp_q  <= cur_resp_d;
      beat_q      <= beat_d;
    end
  end

  // R fields are forced to zero outside a beat so idle outputs are independent of DATA_SEED
  assign r_valid = (state_q == BEAT);
  assign r_last  = r_valid && (beat_q == cur_len_q);
  assign r_id    = r_valid ? cur_id_q : '0;
  assign r_resp  = r_valid ? cur_resp_q : '0;
  assign r_data  = r_valid ? (DATA_WIDTH'(cur_addr_q) ^ DATA_SEED) : '0;
  assign busy    = (|slot_valid_q) | (state_q != IDLE);

endmodule
